// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } pipe_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and hold/clear controls between the pipeline and pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic                  ex_is_load;
  logic                  ex_reg_wen;
  logic [REG_ADDR_W-1:0] ex_waddr;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  dmem_ready;
  logic                  wb_ebreak;

  logic                  stall_if;
  logic                  stall_id;
  logic                  stall_ex;
  logic                  stall_mem;
  logic                  flush_id;
  logic                  flush_ex;
  logic                  bubble_wb;
  logic                  halt;
  logic                  mem_err;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output ex_is_load, ex_reg_wen, ex_waddr, ex_branch_taken,
    output mem_req, dmem_ready, wb_ebreak,
    input  stall_if, stall_id, stall_ex, stall_mem,
    input  flush_id, flush_ex, bubble_wb, halt, mem_err, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  ex_is_load, ex_reg_wen, ex_waddr, ex_branch_taken,
    input  mem_req, dmem_ready, wb_ebreak,
    output stall_if, stall_id, stall_ex, stall_mem,
    output flush_id, flush_ex, bubble_wb, halt, mem_err, stall_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: load in EX feeding a source operand in ID.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_reg_wen_i,
  input  logic [REG_ADDR_W-1:0] ex_waddr_i,
  output logic                  load_use_o
);

  logic rs1_hit;
  logic rs2_hit;
  logic real_dst;

  // x0 is hardwired to zero, so a load targeting it never produces a value to wait for.
  assign real_dst   = ex_is_load_i && ex_reg_wen_i && (ex_waddr_i != REG_ADDR_W'(REG_ZERO));
  assign rs1_hit    = id_rs1_used_i && (id_rs1_i == ex_waddr_i);
  assign rs2_hit    = id_rs2_used_i && (id_rs2_i == ex_waddr_i);
  assign load_use_o = real_dst && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline: Mealy hold/clear
// controls plus registered halt, memory-timeout error and stall counter.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  localparam int                WCNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  pipe_state_t       state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic load_use;
  logic run_eval;
  logic stall_all;
  logic sif, sid, sex, smem, fid, fex, bwb;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .id_rs1_used_i (bus.id_rs1_used),
    .id_rs2_used_i (bus.id_rs2_used),
    .ex_is_load_i  (bus.ex_is_load),
    .ex_reg_wen_i  (bus.ex_reg_wen),
    .ex_waddr_i    (bus.ex_waddr),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    halt_d    = halt_q;
    err_d     = err_q;
    run_eval  = 1'b0;
    stall_all = 1'b0;
    sif       = 1'b0;
    sid       = 1'b0;
    fid       = 1'b0;
    fex       = 1'b0;

    case (state_q)
      RUN: run_eval = 1'b1;
      MEM_WAIT: begin
        // On completion the frozen EX contents get their normal RUN treatment this same cycle.
        if (bus.dmem_ready) begin
          state_d  = RUN;
          run_eval = 1'b1;
        end else begin
          stall_all = 1'b1;
          if (wcnt_q == WCNT_MAX) begin
            err_d   = 1'b1;
            halt_d  = 1'b1;
            state_d = HALT;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      HALT:    stall_all = 1'b1;
      default: state_d = RUN;
    endcase

    if (run_eval) begin
      if (bus.wb_ebreak) begin
        stall_all = 1'b1;
        halt_d    = 1'b1;
        state_d   = HALT;
      end else if (bus.mem_req && !bus.dmem_ready) begin
        stall_all = 1'b1;
        wcnt_d    = WCNT_W'(1);
        state_d   = MEM_WAIT;
      end else if (bus.ex_branch_taken) begin
        // Wrong-path ID instruction: squash rather than stall on its hazards.
        fid = 1'b1;
        fex = 1'b1;
      end else if (load_use) begin
        sif = 1'b1;
        sid = 1'b1;
        fex = 1'b1;
      end
    end

    sif  = (sif || stall_all) && !rst;
    sid  = (sid || stall_all) && !rst;
    sex  = stall_all && !rst;
    smem = stall_all && !rst;
    bwb  = stall_all && !rst;
    fid  = fid && !rst;
    fex  = fex && !rst;

    cnt_d = sif ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_if  = sif;
  assign bus.stall_id  = sid;
  assign bus.stall_ex  = sex;
  assign bus.stall_mem = smem;
  assign bus.flush_id  = fid;
  assign bus.flush_ex  = fex;
  assign bus.bubble_wb = bwb;
  assign bus.halt      = halt_q && !rst;
  assign bus.mem_err   = err_q && !rst;
  assign bus.stall_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with a 4-cycle memory timeout and 4-bit stall counter.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4)) bus ();

  pipe_ctrl #(
    .REG_ADDR_W  (5),
    .MEM_TIMEOUT (4),
    .CNT_W       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb, halt, mem_err}
  logic [8:0] ov;
  assign ov = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
               bus.flush_id, bus.flush_ex, bus.bubble_wb, bus.halt, bus.mem_err};

  localparam logic [8:0] IDLE  = 9'b000000000;
  localparam logic [8:0] LU    = 9'b110001000;
  localparam logic [8:0] BR    = 9'b000011000;
  localparam logic [8:0] STALL = 9'b111100100;
  localparam logic [8:0] HLT   = 9'b111100110;
  localparam logic [8:0] ERRH  = 9'b111100111;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
    bus.ex_is_load = 1'b0; bus.ex_reg_wen = 1'b0; bus.ex_waddr = '0;
    bus.ex_branch_taken = 1'b0; bus.mem_req = 1'b0; bus.dmem_ready = 1'b0;
    bus.wb_ebreak = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] wa);
    bus.ex_is_load = 1'b1; bus.ex_reg_wen = 1'b1; bus.ex_waddr = wa;
  endtask

  // One cycle with the currently driven inputs; expected stall count tracked alongside.
  task automatic cyc(input string tag, input logic [8:0] exp_ov);
    @(negedge clk);
    chk({tag, ".ctl"}, 32'(ov), 32'(exp_ov));
    chk({tag, ".cnt"}, 32'(bus.stall_cnt), 32'(exp_cnt));
    @(posedge clk);
    if (exp_ov[8] && exp_cnt != 15) exp_cnt++;
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, ".rst_ctl"}, 32'(ov), 32'(IDLE));
    chk({tag, ".rst_cnt"}, 32'(bus.stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    do_reset("init");
    cyc("idle", IDLE);

    // Load-use via rs2, then load has left EX
    set_load(5'd5); bus.id_rs2 = 5'd5; bus.id_rs2_used = 1'b1;
    cyc("lu_rs2", LU);
    clr_in();
    cyc("lu_after", IDLE);
    chk("lu_cnt_is_1", 32'(bus.stall_cnt), 32'd1);

    set_load(5'd0); bus.id_rs2 = 5'd0; bus.id_rs2_used = 1'b1;
    cyc("lu_x0", IDLE);
    clr_in(); set_load(5'd7); bus.id_rs1 = 5'd7;
    cyc("lu_rs1_unused", IDLE);
    bus.id_rs1_used = 1'b1;
    cyc("lu_rs1", LU);
    bus.ex_reg_wen = 1'b0;
    cyc("lu_no_wen", IDLE);

    // Branch overrides a concurrent load-use
    bus.ex_reg_wen = 1'b1; bus.ex_branch_taken = 1'b1;
    cyc("br_lu", BR);
    clr_in();

    // Three-cycle memory wait
    bus.mem_req = 1'b1;
    cyc("mw1", STALL);
    cyc("mw2", STALL);
    cyc("mw3", STALL);
    bus.dmem_ready = 1'b1;
    cyc("mw_done", IDLE);
    cyc("zero_wait", IDLE);
    clr_in();
    cyc("mw_cnt", IDLE);
    chk("mw_cnt_is_5", 32'(bus.stall_cnt), 32'd5);

    // Wait completes while a branch sits frozen in EX
    bus.mem_req = 1'b1; bus.ex_branch_taken = 1'b1;
    cyc("mwb_wait", STALL);
    bus.dmem_ready = 1'b1;
    cyc("mwb_release", BR);
    clr_in();

    // Timeout: entry cycle plus four MEM_WAIT cycles, then error halt
    bus.mem_req = 1'b1;
    cyc("to_entry", STALL);
    cyc("to_w1", STALL);
    cyc("to_w2", STALL);
    cyc("to_w3", STALL);
    cyc("to_w4", STALL);
    cyc("to_halt0", ERRH);
    bus.dmem_ready = 1'b1; bus.ex_branch_taken = 1'b1;
    cyc("to_halt1", ERRH);
    clr_in(); set_load(5'd3); bus.id_rs1 = 5'd3; bus.id_rs1_used = 1'b1;
    cyc("to_halt2", ERRH);
    cyc("to_halt3", ERRH);
    cyc("to_halt4", ERRH);
    cyc("to_halt5", ERRH);
    chk("cnt_saturated", 32'(bus.stall_cnt), 32'd15);
    clr_in();
    do_reset("to_rst");
    cyc("to_post", IDLE);

    // Halt on ebreak
    bus.wb_ebreak = 1'b1;
    cyc("ebrk", STALL);
    bus.wb_ebreak = 1'b0;
    cyc("ebrk_h1", HLT);
    bus.mem_req = 1'b1;
    cyc("ebrk_h2", HLT);
    clr_in();
    do_reset("ebrk_rst");
    cyc("ebrk_post", IDLE);

    // Reset during the second MEM_WAIT cycle
    bus.mem_req = 1'b1;
    cyc("rmw_entry", STALL);
    cyc("rmw_w1", STALL);
    do_reset("rmw_rst");
    bus.dmem_ready = 1'b1;
    cyc("rmw_zero_wait", IDLE);
    clr_in();
    cyc("rmw_post", IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the five-stage RV64 pipeline. It decides, every cycle, which pipeline registers hold (IF/ID, ID/EX, EX/MEM, MEM/WB), which are flushed to bubbles, and when the core halts. Inputs are hazard sources: load-use dependencies, taken branches in EX, multi-cycle data-memory accesses in MEM and `ebreak` retiring in WB. It sits beside the pipeline register chain and drives its hold/clear controls.

## Interface
- `REG_ADDR_W`, default 5: register address width.
- `MEM_TIMEOUT`, default 255: maximum MEM wait cycles before an error halt.
- `CNT_W`, default 32: stall performance counter width.

- `clk` in 1: clock. One clock domain; all state updates on the rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `id_rs1`, `id_rs2` in `REG_ADDR_W`: source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used` in 1: each source operand is actually read.
- `ex_is_load` in 1: the instruction in EX is a load.
- `ex_reg_wen` in 1: the instruction in EX writes a register.
- `ex_waddr` in `REG_ADDR_W`: destination register of the instruction in EX.
- `ex_branch_taken` in 1: the instruction in EX redirects the PC (branch or jump).
- `mem_req` in 1: the instruction in MEM is a valid load or store.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `wb_ebreak` in 1: `ebreak` is in WB this cycle.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem` out 1: hold the PC/IF-ID, ID-EX, EX-MEM and MEM-WB register inputs respectively.
- `flush_id`, `flush_ex` out 1: load a bubble into IF/ID or ID/EX.
- `bubble_wb` out 1: MEM/WB captures a bubble (`reg_wen=0`, `ebreak_flag=0`).
- `halt` out 1: the core has stopped; sticky.
- `mem_err` out 1: a MEM wait timed out; sticky.
- `stall_cnt` out `CNT_W`: saturating count of cycles with `stall_if=1`.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Reset state is RUN.
- Outputs are Mealy: combinational from the current state and inputs. Exceptions are `halt`, `mem_err` and `stall_cnt`, which are registered.
- While `rst=1`: every output is 0 and `stall_cnt=0`.
- Priority in RUN, highest first: `wb_ebreak` > MEM wait > branch flush > load-use.
  - `wb_ebreak`:
    - Outputs: all stall outputs =1, `bubble_wb=1`.
    - Next state: HALT.
  - MEM wait (`mem_req & ~dmem_ready`):
    - Outputs: `stall_if/id/ex/mem=1`, `bubble_wb=1`, no flushes.
    - Next state: MEM_WAIT, wait counter loaded with 1.
  - Taken branch (`ex_branch_taken`):
    - Outputs: `flush_id=1`, `flush_ex=1`, no stalls.
    - A concurrent load-use match is ignored, because the ID instruction is wrong-path.
  - Load-use: `ex_is_load & ex_reg_wen & ex_waddr!=0 & ((id_rs1_used & id_rs1==ex_waddr) | (id_rs2_used & id_rs2==ex_waddr))`.
    - Outputs: `stall_if=1`, `stall_id=1`, `flush_ex=1`.
    - EX/MEM and MEM/WB keep advancing.
- MEM_WAIT:
  - Outputs: same stall pattern as entry.
  - Flushes and load-use are suppressed; branch and load state stay frozen in EX.
  - `dmem_ready=1`: stalls drop in that same cycle, MEM/WB captures the real result, next state RUN. A pending branch or load-use is then evaluated in that same cycle per RUN rules.
  - Otherwise the counter increments. When the counter equals `MEM_TIMEOUT` and `dmem_ready=0`: `mem_err<=1`, next state HALT.
  - `wb_ebreak` cannot occur in MEM_WAIT, because WB holds a bubble.
- HALT:
  - All stall outputs =1, `bubble_wb=1`, `halt=1`.
  - Exits only on `rst`.
- `stall_cnt` increments on every cycle with `stall_if=1` and saturates at all-ones.
- `x0` as destination never causes a load-use stall.

## Timing
- Zero-wait memory (`mem_req & dmem_ready` in the same cycle): no stall and no state change.
- A load-use hazard costs exactly 1 bubble cycle. On the next cycle the load has moved to MEM, so no match remains.
- Branch penalty: 2 instructions squashed, 0 stall cycles.
- `halt` rises the cycle after `wb_ebreak` is sampled. In the sampling cycle the stall outputs are already 1.
- `mem_err` and `halt` rise together, on the edge ending the `MEM_TIMEOUT`-th wait cycle.
- `rst` asserted mid-MEM_WAIT or in HALT: state returns to RUN and the counter, `halt`, `mem_err` and `stall_cnt` clear on that edge.

## Structure
- Shared package `pipe_pkg` holds:
  - State enum `pipe_state_t` with RUN=0, MEM_WAIT=1, HALT=2.
  - Constant `REG_ZERO=0`.
- Sub-module `hazard_detect` is purely combinational and produces `load_use`. All other logic stays in `pipe_ctrl`.

## Test plan
- Load-use:
  - Stimulus: load in EX with `ex_waddr=5`; ID has `id_rs2=5`, `id_rs2_used=1`.
  - Required: one cycle of `stall_if=stall_id=flush_ex=1`; `stall_cnt`=1.
  - Repeat with `ex_waddr=0`: no stall.
- Branch plus load-use:
  - Stimulus: `ex_branch_taken=1` while a load-use match is also present.
  - Required: `flush_id=flush_ex=1`, all stalls 0.
- Three-cycle memory wait:
  - Stimulus: `mem_req=1`, `dmem_ready` low for 3 cycles, then high.
  - Required: stalls and `bubble_wb` high for 3 cycles, released in cycle 4, state RUN, `stall_cnt`=3.
- Timeout:
  - Stimulus: `MEM_TIMEOUT=4`, `dmem_ready` held 0.
  - Required: `mem_err=halt=1` after the 4th wait cycle, outputs frozen until `rst`.
- Halt on ebreak:
  - Stimulus: `wb_ebreak=1` in RUN.
  - Required: `halt` high from the next cycle.
  - Then assert `rst` for 1 cycle: all outputs 0, state RUN.
- Reset mid-wait:
  - Stimulus: `rst` pulsed in the 2nd cycle of MEM_WAIT.
  - Required: counter cleared; the next `mem_req & dmem_ready` causes no stall.
